// File: rtl/gerador_seq_pkg.sv
// Shared definitions for the serial stimulus generator: FSM state codes and
// default parameter values used by the top level and by its benches.
package gerador_seq_pkg;

    // State encoding is fixed so that detector-side benches can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int N_DEF   = 8;   // pattern width
    localparam int LW_DEF  = 4;   // len width, holds 0..N
    localparam int RW_DEF  = 4;   // reps width
    localparam int GAP_DEF = 2;   // idle cycles between repetitions
    localparam int MSB_DEF = 1;   // 1: pat[len-1] goes out first

endpackage

// File: rtl/gerador_seq_reg_desloca.sv
// N-bit loadable shift register. The outgoing bit is always the head of the
// register in the selected direction, so it is a flop output.
module reg_desloca #(
    parameter int N = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         msb_first,
    input  logic [N-1:0] d,
    output logic         q_out
);

    logic [N-1:0] q;

    // Load has priority over shift; vacated positions fill with zero.
    always_ff @(posedge ck) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            if (msb_first) begin
                q <= {q[N-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[N-1:1]};
            end
        end
    end

    assign q_out = msb_first ? q[N-1] : q[0];

endmodule

// File: rtl/gerador_seq.sv
// Serial stimulus generator: captures pat/len/reps on start, then sends the
// low len bits of pat serially on w, reps times, with GAP idle cycles between
// repetitions, and pulses done once at the end. stop aborts without done.
module gerador_seq
    import gerador_seq_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int LW  = LW_DEF,
    parameter int RW  = RW_DEF,
    parameter int GAP = GAP_DEF,
    parameter int MSB = MSB_DEF
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [N-1:0]  pat,
    input  logic [LW-1:0] len,
    input  logic [RW-1:0] reps,
    output logic          w,
    output logic          w_valid,
    output logic          busy,
    output logic          done
);

    // Gap counter only needs to reach GAP-1; keep at least one bit.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state;
    logic [N-1:0]    pat_q;
    logic [LW-1:0]   len_q;
    logic [RW-1:0]   reps_q;
    logic [LW-1:0]   bit_cnt;
    logic [RW-1:0]   rep_cnt;
    logic [GW-1:0]   gap_cnt;

    logic [LW-1:0]   len_in_c;
    logic            accept;
    logic            req_empty;
    logic            last_bit;
    logic            more_reps;
    logic            gap_end;
    logic            sh_load;
    logic            sh_shift;
    logic [N-1:0]    sh_d;
    logic            sh_out;

    // Place the first bit to send at the shifter head. In MSB-first mode the
    // pattern is moved up so pat[l-1] lands on bit N-1; in LSB-first mode
    // pat[0] is already at the head.
    function automatic logic [N-1:0] align(input logic [N-1:0] p, input logic [LW-1:0] l);
        logic [N-1:0] r;
        if (MSB != 0) begin
            r = p << (N - int'(l));
        end else begin
            r = p;
        end
        return r;
    endfunction

    // Request decoding, end-of-repetition conditions and shifter control.
    always_comb begin
        len_in_c  = (int'(len) > N) ? LW'(N) : len;
        accept    = (state == ST_IDLE) && start && !stop;
        req_empty = (len_in_c == '0) || (reps == '0);
        last_bit  = (bit_cnt == len_q - 1'b1);
        more_reps = (rep_cnt != reps_q - 1'b1);
        gap_end   = (int'(gap_cnt) >= GAP - 1);

        // The shifter is (re)loaded on every edge that enters SHIFT.
        sh_load = 1'b0;
        if (accept && !req_empty) begin
            sh_load = 1'b1;
        end else if (!stop && state == ST_SHIFT && last_bit && more_reps && GAP == 0) begin
            sh_load = 1'b1;
        end else if (!stop && state == ST_GAP && gap_end) begin
            sh_load = 1'b1;
        end
        sh_shift = !stop && (state == ST_SHIFT) && !sh_load;

        // At accept the captured copy is not written yet, so load from the
        // inputs directly; afterwards only the captured copy is used.
        sh_d = (state == ST_IDLE) ? align(pat, len_in_c) : align(pat_q, len_q);
    end

    reg_desloca #(
        .N (N)
    ) u_shift (
        .ck        (ck),
        .rst       (rst),
        .load      (sh_load),
        .shift     (sh_shift),
        .msb_first (MSB != 0),
        .d         (sh_d),
        .q_out     (sh_out)
    );

    // Control FSM with bit/rep/gap counters and registered status outputs.
    always_ff @(posedge ck) begin
        if (rst) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            reps_q  <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (stop && state != ST_IDLE) begin
            // Abort: straight back to IDLE, no done pulse.
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pat_q   <= pat;
                        len_q   <= len_in_c;
                        reps_q  <= reps;
                        bit_cnt <= '0;
                        rep_cnt <= '0;
                        gap_cnt <= '0;
                        busy    <= 1'b1;
                        if (req_empty) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT;
                            w_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (more_reps) begin
                            rep_cnt <= rep_cnt + 1'b1;
                            if (GAP != 0) begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                                w_valid <= 1'b0;
                            end
                        end else begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            w_valid <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        state   <= ST_SHIFT;
                        gap_cnt <= '0;
                        w_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Both terms are flops, so w is forced low whenever w_valid is low.
    assign w = w_valid & sh_out;

endmodule

// File: tb/tb_gerador_seq.sv
// Bench for gerador_seq: expected per-cycle outputs are queued when a request
// is driven and popped/compared one cycle at a time.
module tb_gerador_seq;

    localparam int N   = 8;
    localparam int LW  = 4;
    localparam int RW  = 4;
    localparam int GAP = 2;
    localparam int MSB = 1;

    logic          ck;
    logic          rst;
    logic          start;
    logic          stop;
    logic [N-1:0]  pat;
    logic [LW-1:0] len;
    logic [RW-1:0] reps;
    logic          w;
    logic          w_valid;
    logic          busy;
    logic          done;

    int tests_run    = 0;
    int tests_failed = 0;

    gerador_seq #(
        .N   (N),
        .LW  (LW),
        .RW  (RW),
        .GAP (GAP),
        .MSB (MSB)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pat     (pat),
        .len     (len),
        .reps    (reps),
        .w       (w),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b, expected %0b", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] e);
        chk({tag, " w_valid"}, w_valid, e[3]);
        chk({tag, " w"},       w,       e[2]);
        chk({tag, " busy"},    busy,    e[1]);
        chk({tag, " done"},    done,    e[0]);
    endtask

    // One request: build the expected stream, pulse start, then compare one
    // record per cycle. stop_idx >= 0 raises stop after that record;
    // disturb keeps toggling start/pat/len/reps while the run is busy.
    task automatic run(input string name, input logic [N-1:0] p, input int l,
                       input int r, input int stop_idx, input bit disturb);
        logic [3:0] exp_q[$];
        logic [3:0] e;
        int le;
        int idx;
        le = (l > N) ? N : l;
        if (le == 0 || r == 0) begin
            exp_q.push_back(4'b0011);
        end else begin
            for (int k = 0; k < r; k++) begin
                for (int i = 0; i < le; i++) begin
                    e = 4'b1010;
                    e[2] = (MSB != 0) ? p[le-1-i] : p[i];
                    exp_q.push_back(e);
                end
                if (k < r - 1) begin
                    for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
                end
            end
            exp_q.push_back(4'b0011);
        end
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);

        @(negedge ck);
        pat   = p;
        len   = LW'(l);
        reps  = RW'(r);
        start = 1'b1;
        @(posedge ck);
        #1;
        start = 1'b0;

        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge ck);
            e = exp_q.pop_front();
            chk_outs($sformatf("%s#%0d", name, idx), e);
            if (disturb) begin
                if (exp_q.size() > 1) begin
                    start = 1'b1;
                    pat   = N'($urandom);
                    len   = LW'($urandom_range(0, 15));
                    reps  = RW'($urandom_range(0, 15));
                end else begin
                    start = 1'b0;
                end
            end
            if (idx == stop_idx) begin
                stop = 1'b1;
                exp_q.delete();
                exp_q.push_back(4'b0000);
                exp_q.push_back(4'b0000);
            end else begin
                stop = 1'b0;
            end
            idx++;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        pat   = 8'hFF;
        len   = 4'd4;
        reps  = 4'd1;

        // Reset held two cycles with start high.
        repeat (2) begin
            @(posedge ck);
            @(negedge ck);
            chk_outs("reset", 4'b0000);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge ck);
        @(negedge ck);
        chk_outs("after_reset", 4'b0000);

        run("basic",     8'b1011_0110, 4, 1, -1, 1'b0);
        run("gap3x3",    8'b0000_0101, 3, 3, -1, 1'b0);
        run("len0",      8'hA5,        0, 3, -1, 1'b0);
        run("reps0",     8'hA5,        5, 0, -1, 1'b0);
        run("stop",      8'b0000_0101, 3, 3,  6, 1'b0);
        run("post_stop", 8'b1100_1010, 5, 2, -1, 1'b0);

        // start and stop together in IDLE: no capture.
        @(negedge ck);
        pat   = 8'hFF;
        len   = 4'd3;
        reps  = 4'd1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge ck);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge ck);
        chk_outs("start_stop", 4'b0000);
        @(negedge ck);
        chk_outs("start_stop+1", 4'b0000);

        run("disturb",   8'b1001_1101, 6, 2, -1, 1'b1);
        run("clamp",     8'b1110_0101, 9, 2, -1, 1'b0);
        run("max",       8'b0110_1001, 8, 15, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
